// File: rtl/core_pkg.sv
// core_pkg: shared defaults and state encoding for the core memory controller
// and its sequencer (core_control).
//   DATA_W / ADDR_W / DEPTH : operand width, buffer address width, buffer depth
//   ST_*                    : controller state encoding (3-bit, legacy-compatible)
package core_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_READ = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;
endpackage

// File: rtl/core_mc_ram.sv
// core_mc_ram: DEPTH x DATA_W operand buffer with one write port and one
// synchronous read port.
//   clk, rst_n          : clock, async active-low reset (read register only)
//   we, waddr, wdata    : write port
//   re, raddr           : read enable / address, sampled on the rising edge
//   rdata               : registered read data
// A read and a write to the same address on the same edge return the
// old contents.
module core_mc_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/core_mem_ctrl.sv
// core_mem_ctrl: operand memory controller behind core_control.
// Loads a host batch (valid/last) into a DEPTH-entry buffer, reports length
// and completion, then streams operands to the FPU on request.
// Optional macro MC_WRITEBACK_EN adds result write-back ports
// (mc_we, mc_wb_addr, mc_wb_data), accepted only in READ and DONE.
// Ports:
//   mc_clk, mc_reset                 : clock, async active-low reset
//   mc_start_load                    : start new batch, aborts everything
//   mc_in_data/valid/last/ready      : host load channel
//   mc_data_done, mc_data_length     : batch loaded flag, word count
//   mc_rd_req, mc_rd_data, mc_rd_valid : operand read channel (1-cycle latency)
//   mc_data_address_out              : read pointer
//   mc_cont_procc, mc_done           : operands remaining / all consumed
//   mc_err                           : sticky overflow / bad write-back
module core_mem_ctrl #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int ADDR_W = core_pkg::ADDR_W,
  parameter int DEPTH  = core_pkg::DEPTH
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic              mc_start_load,
  input  logic [DATA_W-1:0] mc_in_data,
  input  logic              mc_in_valid,
  input  logic              mc_in_last,
  output logic              mc_in_ready,
  output logic              mc_data_done,
  output logic [ADDR_W:0]   mc_data_length,
  input  logic              mc_rd_req,
  output logic [DATA_W-1:0] mc_rd_data,
  output logic              mc_rd_valid,
  output logic [ADDR_W-1:0] mc_data_address_out,
  output logic              mc_cont_procc,
  output logic              mc_done,
`ifdef MC_WRITEBACK_EN
  input  logic              mc_we,
  input  logic [ADDR_W-1:0] mc_wb_addr,
  input  logic [DATA_W-1:0] mc_wb_data,
`endif
  output logic              mc_err
);
  import core_pkg::*;

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   rd_ptr;   // one extra bit so a full batch compares cleanly
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   rd_ptr_n;

  logic              host_acc;
  logic              rd_iss;
  logic              wb_ok;
  logic              wb_bad;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // mc_in_ready mirrors state==LOAD, so it doubles as the accept qualifier.
  assign host_acc = mc_in_ready && mc_in_valid && !mc_start_load;
  assign rd_iss   = (state == ST_READ) && mc_rd_req && (rd_ptr < len) && !mc_start_load;
  assign rd_ptr_n = rd_ptr + 1'b1;

`ifdef MC_WRITEBACK_EN
  logic wb_st;
  assign wb_st  = ((state == ST_READ) || (state == ST_DONE)) && mc_we && !mc_start_load;
  assign wb_ok  = wb_st && ({1'b0, mc_wb_addr} < len);
  assign wb_bad = wb_st && ({1'b0, mc_wb_addr} >= len);
  // Host writes only in LOAD, write-back only in READ/DONE: never both.
  assign ram_we    = host_acc || wb_ok;
  assign ram_waddr = host_acc ? wr_ptr : mc_wb_addr;
  assign ram_wdata = host_acc ? mc_in_data : mc_wb_data;
`else
  assign wb_ok     = 1'b0;
  assign wb_bad    = 1'b0;
  assign ram_we    = host_acc;
  assign ram_waddr = wr_ptr;
  assign ram_wdata = mc_in_data;
`endif

  core_mc_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (mc_clk),
    .rst_n (mc_reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_iss),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (mc_rd_data)
  );

  assign mc_data_length      = len;
  assign mc_data_address_out = rd_ptr[ADDR_W-1:0];

  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      state         <= ST_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      len           <= '0;
      mc_in_ready   <= 1'b0;
      mc_data_done  <= 1'b0;
      mc_rd_valid   <= 1'b0;
      mc_cont_procc <= 1'b0;
      mc_done       <= 1'b0;
      mc_err        <= 1'b0;
    end else if (mc_start_load) begin
      // Abort: also drops the read that would have completed this edge.
      state         <= ST_LOAD;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      len           <= '0;
      mc_in_ready   <= 1'b1;
      mc_data_done  <= 1'b0;
      mc_rd_valid   <= 1'b0;
      mc_cont_procc <= 1'b0;
      mc_done       <= 1'b0;
      mc_err        <= 1'b0;
    end else begin
      mc_rd_valid <= rd_iss;
      case (state)
        ST_LOAD: if (host_acc) begin
          wr_ptr <= wr_ptr + 1'b1;
          len    <= len + 1'b1;
          if (mc_in_last) begin
            state         <= ST_READ;
            mc_in_ready   <= 1'b0;
            mc_data_done  <= 1'b1;
            mc_cont_procc <= 1'b1;
          end else if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
            state       <= ST_ERR;
            mc_in_ready <= 1'b0;
            mc_err      <= 1'b1;
          end
        end
        ST_READ: if (rd_iss) begin
          rd_ptr <= rd_ptr_n;
          if (rd_ptr_n == len) begin
            state         <= ST_DONE;
            mc_cont_procc <= 1'b0;
            mc_done       <= 1'b1;
          end
        end
        default: ;
      endcase
      if (wb_bad) mc_err <= 1'b1;
    end
  end
endmodule
